// File: rtl/me_job_seq.sv
// me_job_seq: job sequencer in front of the IDDMM modular exponentiator.
// Optional WAIT_RES watchdog is built in when ME_SEQ_TIMEOUT_EN is defined.
module me_job_seq #(
    parameter int K              = 128,
    parameter int N              = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K*N-1:0] in_x,
    input  logic [K*N-1:0] in_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [K*N-1:0] out_result,
    output logic           busy,
    output logic           me_start,
    output logic [K-1:0]   me_x,
    output logic           me_x_valid,
    output logic [K-1:0]   me_y,
    output logic           me_y_valid,
    input  logic [K-1:0]   me_result,
    input  logic           me_valid,
    output logic           timeout_err
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] LAST_W = CW'(N - 1);
    localparam logic [GW-1:0] LAST_G = GW'(GAP_CYCLES - 1);

    if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("me_job_seq: GAP_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD_Y,
        START,
        LOAD_X,
        WAIT_RES,
        GAP,
        OUT
    } state_t;

    state_t          r_state;
    state_t          w_nxt_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_nxt_cnt;
    logic [GW-1:0]   r_gap;
    logic [GW-1:0]   w_nxt_gap;
    logic            w_accept;
    logic            w_res_we;
    logic            w_clr_res;
    logic            w_timeout;
    logic            w_abort;
    logic [IW-1:0]   w_cur_idx;
    logic [IW-1:0]   w_nxt_idx;
    logic [K-1:0]    w_y_word;

    logic [K-1:0]    r_x_w   [N];
    logic [K-1:0]    r_y_w   [N];
    logic [K-1:0]    r_res_w [N];

    logic            r_me_start;
    logic [K-1:0]    r_me_x;
    logic            r_me_x_valid;
    logic [K-1:0]    r_me_y;
    logic            r_me_y_valid;

    assign in_ready   = (r_state == IDLE) && !rst;
    assign busy       = (r_state != IDLE);
    assign out_valid  = (r_state == OUT);
    assign me_start   = r_me_start;
    assign me_x       = r_me_x;
    assign me_x_valid = r_me_x_valid;
    assign me_y       = r_me_y;
    assign me_y_valid = r_me_y_valid;

    assign w_cur_idx  = r_cnt[IW-1:0];
    assign w_nxt_idx  = w_nxt_cnt[IW-1:0];
    // word 0 of y goes out on the accept edge, before r_y_w holds it
    assign w_y_word   = (r_state == IDLE) ? in_y[K-1:0] : r_y_w[w_nxt_idx];

    for (genvar g = 0; g < N; g++) begin : g_res
        assign out_result[g*K +: K] = r_res_w[g];
    end

`ifdef ME_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST_T = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_abort;
    logic          r_timeout_err;

    assign w_timeout   = (r_state == WAIT_RES) && !me_valid &&
                         (r_to_cnt == LAST_T);
    assign w_abort     = r_abort;
    assign timeout_err = r_timeout_err;

    // watchdog: counts silent WAIT_RES cycles, aborted job skips OUT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_abort       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == WAIT_RES && !me_valid && !w_timeout)
                r_to_cnt <= r_to_cnt + 1'b1;
            else
                r_to_cnt <= '0;
            if (w_timeout) begin
                r_abort       <= 1'b1;
                r_timeout_err <= 1'b1;
            end else if (r_state == GAP && w_nxt_state != GAP) begin
                r_abort <= 1'b0;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign w_abort     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // state, word counter and gap counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_gap   <= w_nxt_gap;
        end
    end

    // next-state, counter and result-write decode
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_gap   = r_gap;
        w_accept    = 1'b0;
        w_res_we    = 1'b0;
        w_clr_res   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    w_accept    = 1'b1;
                    w_nxt_state = LOAD_Y;
                    w_nxt_cnt   = '0;
                end
            end
            LOAD_Y: begin
                if (r_cnt == LAST_W) begin
                    w_nxt_state = START;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            START: begin
                w_nxt_state = LOAD_X;
                w_nxt_cnt   = '0;
            end
            LOAD_X: begin
                if (r_cnt == LAST_W) begin
                    w_nxt_state = WAIT_RES;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            WAIT_RES: begin
                if (me_valid) begin
                    w_res_we = 1'b1;
                    if (r_cnt == LAST_W) begin
                        w_nxt_state = GAP;
                        w_nxt_cnt   = '0;
                        w_nxt_gap   = '0;
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end else if (w_timeout) begin
                    w_clr_res   = 1'b1;
                    w_nxt_state = GAP;
                    w_nxt_cnt   = '0;
                    w_nxt_gap   = '0;
                end
            end
            GAP: begin
                if (r_gap == LAST_G) begin
                    w_nxt_state = w_abort ? IDLE : OUT;
                    w_nxt_gap   = '0;
                end else begin
                    w_nxt_gap = r_gap + 1'b1;
                end
            end
            OUT: begin
                if (out_ready)
                    w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_cnt   = '0;
                w_nxt_gap   = '0;
            end
        endcase
    end

    // operand capture on accept
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < N; i++) begin
                r_x_w[i] <= in_x[i*K +: K];
                r_y_w[i] <= in_y[i*K +: K];
            end
        end
    end

    // result assembled in place, cleared on new job or abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                r_res_w[i] <= '0;
        end else if (w_accept || w_clr_res) begin
            for (int i = 0; i < N; i++)
                r_res_w[i] <= '0;
        end else if (w_res_we) begin
            r_res_w[w_cur_idx] <= me_result;
        end
    end

    // registered exponentiator-side strobes, decoded from next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_me_start   <= 1'b0;
            r_me_x       <= '0;
            r_me_x_valid <= 1'b0;
            r_me_y       <= '0;
            r_me_y_valid <= 1'b0;
        end else begin
            r_me_start   <= (w_nxt_state == START);
            r_me_y_valid <= (w_nxt_state == LOAD_Y);
            r_me_y       <= (w_nxt_state == LOAD_Y) ? w_y_word : '0;
            r_me_x_valid <= (w_nxt_state == LOAD_X);
            r_me_x       <= (w_nxt_state == LOAD_X) ?
                            r_x_w[w_nxt_idx] : '0;
        end
    end

endmodule

// File: tb/tb_me_job_seq.sv
// tb_me_job_seq: directed bench for me_job_seq.
// Bench acts as the exponentiator; timeout step only with ME_SEQ_TIMEOUT_EN.
module tb_me_job_seq;

    localparam int K   = 128;
    localparam int N   = 16;
    localparam int GAP = 4;
    localparam int TO  = 100;
    localparam int M   = 13;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [K*N-1:0] in_x = '0;
    logic [K*N-1:0] in_y = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [K*N-1:0] out_result;
    logic           busy;
    logic           me_start;
    logic [K-1:0]   me_x;
    logic           me_x_valid;
    logic [K-1:0]   me_y;
    logic           me_y_valid;
    logic [K-1:0]   me_result = '0;
    logic           me_valid = 1'b0;
    logic           timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [K-1:0] cap_x [N];
    logic [K-1:0] cap_y [N];

    me_job_seq #(
        .K(K), .N(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .busy(busy),
        .me_start(me_start),
        .me_x(me_x), .me_x_valid(me_x_valid),
        .me_y(me_y), .me_y_valid(me_y_valid),
        .me_result(me_result), .me_valid(me_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [K-1:0] obs,
                       input logic [K-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int modexp(int b, int e, int m);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % m;
        return r;
    endfunction

    task automatic send_job(input logic [K*N-1:0] x, input logic [K*N-1:0] y);
        chk("in_ready_before_job", {127'd0, in_ready}, 1);
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // observe y stream, start pulse, then nx words of the x stream
    task automatic load_chk(input logic [K*N-1:0] x, input logic [K*N-1:0] y,
                            input int nx);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("y_valid[%0d]", i), {127'd0, me_y_valid}, 1);
            chk($sformatf("me_y[%0d]", i), me_y, y[i*K +: K]);
            chk($sformatf("busy_ld[%0d]", i), {127'd0, busy}, 1);
            cap_y[i] = me_y;
            @(negedge clk);
        end
        chk("me_start", {127'd0, me_start}, 1);
        chk("y_valid_off", {127'd0, me_y_valid}, 0);
        chk("x_valid_at_start", {127'd0, me_x_valid}, 0);
        @(negedge clk);
        for (int i = 0; i < nx; i++) begin
            chk($sformatf("x_valid[%0d]", i), {127'd0, me_x_valid}, 1);
            chk($sformatf("me_x[%0d]", i), me_x, x[i*K +: K]);
            chk($sformatf("start_low[%0d]", i), {127'd0, me_start}, 0);
            cap_x[i] = me_x;
            @(negedge clk);
        end
    endtask

    // return N words with up to maxgap idle cycles before each, then GAP
    task automatic feed(input logic [K*N-1:0] r, input int maxgap);
        chk("x_valid_off", {127'd0, me_x_valid}, 0);
        for (int i = 0; i < N; i++) begin
            int g;
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (g) begin
                chk($sformatf("busy_gap[%0d]", i), {127'd0, busy}, 1);
                @(negedge clk);
            end
            me_valid  = 1'b1;
            me_result = r[i*K +: K];
            chk($sformatf("busy_res[%0d]", i), {127'd0, busy}, 1);
            chk($sformatf("out_valid_wait[%0d]", i), {127'd0, out_valid}, 0);
            @(negedge clk);
            me_valid  = 1'b0;
            me_result = '0;
        end
        for (int i = 0; i < GAP; i++) begin
            chk($sformatf("out_valid_gap[%0d]", i), {127'd0, out_valid}, 0);
            chk($sformatf("busy_gapst[%0d]", i), {127'd0, busy}, 1);
            @(negedge clk);
        end
        chk("out_valid_after_gap", {127'd0, out_valid}, 1);
    endtask

    task automatic res_chk(input string tag, input logic [K*N-1:0] e);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s[%0d]", tag, i), out_result[i*K +: K], e[i*K +: K]);
    endtask

    task automatic take_out;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", {127'd0, out_valid}, 0);
        chk("in_ready_after_out", {127'd0, in_ready}, 1);
        chk("busy_after_out", {127'd0, busy}, 0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_in_ready"}, {127'd0, in_ready}, 0);
        chk({tag, "_out_valid"}, {127'd0, out_valid}, 0);
        chk({tag, "_busy"}, {127'd0, busy}, 0);
        chk({tag, "_me_start"}, {127'd0, me_start}, 0);
        chk({tag, "_x_valid"}, {127'd0, me_x_valid}, 0);
        chk({tag, "_y_valid"}, {127'd0, me_y_valid}, 0);
        chk({tag, "_me_x"}, me_x, 0);
        chk({tag, "_me_y"}, me_y, 0);
        chk({tag, "_timeout_err"}, {127'd0, timeout_err}, 0);
        chk({tag, "_out_result_zero"}, {127'd0, (out_result == '0)}, 1);
    endtask

    initial begin
        logic [K*N-1:0] x;
        logic [K*N-1:0] y;
        logic [K*N-1:0] r;
        logic [K*N-1:0] e;

        // reset state
        @(negedge clk);
        all_zero("reset");
        rst = 1'b0;
        #1;
        chk("in_ready_post_reset", {127'd0, in_ready}, 1);
        @(negedge clk);

        // basic: 2^3 mod 13 = 8
        x = '0; x[K-1:0] = 128'd2;
        y = '0; y[K-1:0] = 128'd3;
        send_job(x, y);
        load_chk(x, y, N);
        r = '0;
        r[K-1:0] = K'(modexp(int'(cap_x[0][7:0]), int'(cap_y[0][7:0]), M));
        feed(r, 0);
        e = '0; e[K-1:0] = 128'd8;
        res_chk("basic", e);
        take_out();

        // load ordering and backpressure
        for (int i = 0; i < N; i++) begin
            x[i*K +: K] = K'(32'h200 + i);
            y[i*K +: K] = K'(32'h100 + i);
            r[i*K +: K] = {32'hC0DE_0000 + 32'(i), 96'h5A5A};
        end
        e = r;
        send_job(x, y);
        load_chk(x, y, N);
        feed(r, 0);
        for (int c = 0; c < 10; c++) begin
            me_valid  = (c == 3);
            me_result = '1;
            chk($sformatf("bp_valid[%0d]", c), {127'd0, out_valid}, 1);
            chk($sformatf("bp_in_ready[%0d]", c), {127'd0, in_ready}, 0);
            chk($sformatf("bp_strobes[%0d]", c),
                {125'd0, me_start, me_x_valid, me_y_valid}, 0);
            chk($sformatf("bp_w0[%0d]", c), out_result[K-1:0], e[K-1:0]);
            chk($sformatf("bp_w15[%0d]", c), out_result[K*N-1 -: K],
                e[K*N-1 -: K]);
            @(negedge clk);
        end
        me_valid  = 1'b0;
        me_result = '0;
        res_chk("bp", e);
        take_out();

        // stray result pulse in IDLE, then gapped result words
        me_valid  = 1'b1;
        me_result = 128'hDEAD;
        @(negedge clk);
        me_valid  = 1'b0;
        me_result = '0;
        chk("stray_busy", {127'd0, busy}, 0);
        chk("stray_in_ready", {127'd0, in_ready}, 1);
        for (int i = 0; i < N; i++) begin
            x[i*K +: K] = K'(32'h3000 + i * 7);
            y[i*K +: K] = K'(32'h4000 + i * 5);
            r[i*K +: K] = K'(32'h1111 * (i + 1));
        end
        e = r;
        send_job(x, y);
        load_chk(x, y, N);
        feed(r, 5);
        res_chk("gapped", e);
        take_out();

        // reset after 7 x words, then a fresh job: 3^4 mod 13 = 3
        send_job(x, y);
        load_chk(x, y, 7);
        rst = 1'b1;
        #1;
        all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", {127'd0, in_ready}, 1);
        chk("midrst_busy", {127'd0, busy}, 0);
        @(negedge clk);
        x = '0; x[K-1:0] = 128'd3;
        y = '0; y[K-1:0] = 128'd4;
        send_job(x, y);
        load_chk(x, y, N);
        r = '0;
        r[K-1:0] = K'(modexp(int'(cap_x[0][7:0]), int'(cap_y[0][7:0]), M));
        feed(r, 0);
        e = '0; e[K-1:0] = 128'd3;
        res_chk("after_rst", e);
        take_out();

`ifdef ME_SEQ_TIMEOUT_EN
        // watchdog: no result words ever come back
        send_job(x, y);
        load_chk(x, y, N);
        for (int c = 1; c < TO; c++) begin
            chk($sformatf("to_err_early[%0d]", c), {127'd0, timeout_err}, 0);
            chk($sformatf("to_out_valid[%0d]", c), {127'd0, out_valid}, 0);
            @(negedge clk);
        end
        chk("to_err_last_low", {127'd0, timeout_err}, 0);
        @(negedge clk);
        chk("to_err_set", {127'd0, timeout_err}, 1);
        for (int c = 0; c < GAP; c++) begin
            chk($sformatf("to_gap_busy[%0d]", c), {127'd0, busy}, 1);
            chk($sformatf("to_gap_valid[%0d]", c), {127'd0, out_valid}, 0);
            @(negedge clk);
        end
        chk("to_in_ready", {127'd0, in_ready}, 1);
        chk("to_out_valid_idle", {127'd0, out_valid}, 0);
        chk("to_sticky", {127'd0, timeout_err}, 1);
        chk("to_result_cleared", {127'd0, (out_result == '0)}, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
